// File: rtl/reg_file_sb.sv
// Register file with a per-register busy scoreboard and a registered busy counter.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_SB_BYPASS_EN.
module reg_file_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr,
    input  logic            flush,
    output logic [AW:0]     busy_count
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            wr_ok;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign wr_ok = wr_en && (rd_addr != '0);

    // Write clears the target's busy bit first; a same-cycle issue then re-sets it,
    // while flush overrides both and suppresses the issue.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[rd_addr] = 1'b0;
        end
        if (flush) begin
            busy_nxt = '0;
        end else if (issue_en && (issue_addr != '0)) begin
            busy_nxt[issue_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_ok) begin
                regs[rd_addr] <= rd_data;
            end
            busy       <= busy_nxt;
            busy_count <= popcount(busy_nxt);
        end
    end

`ifdef REG_FILE_SB_BYPASS_EN
    logic byp1;
    logic byp2;
    logic issue_hit;

    // Forwarding is gated by reset so a write presented during reset stays invisible.
    assign byp1      = reset && wr_ok && (rs1_addr == rd_addr);
    assign byp2      = reset && wr_ok && (rs2_addr == rd_addr);
    assign issue_hit = issue_en && !flush && (issue_addr == rd_addr);

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
        rs1_busy = busy[rs1_addr];
        rs2_busy = busy[rs2_addr];
        if (byp1) begin
            rs1_data = rd_data;
            rs1_busy = issue_hit;
        end
        if (byp2) begin
            rs2_data = rd_data;
            rs2_busy = issue_hit;
        end
    end
`else
    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
        rs1_busy = busy[rs1_addr];
        rs2_busy = busy[rs2_addr];
    end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against an array-based model of the register file.
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            rs1_busy, rs2_busy;
    logic            wr_en;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            issue_en;
    logic [AW-1:0]   issue_addr;
    logic            flush;
    logic [AW:0]     busy_count;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    reg_file_sb #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .wr_en      (wr_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .flush      (flush),
        .busy_count (busy_count)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register contents and busy set.
    logic [XLEN-1:0] m_regs [NREG];
    logic [NREG-1:0] m_busy;

    always @(posedge clk or negedge reset) begin : model_upd
        logic [NREG-1:0] nb;
        if (!reset) begin
            for (int i = 0; i < NREG; i++) m_regs[i] <= '0;
            m_busy <= '0;
        end else begin
            nb = m_busy;
            if (wr_en && rd_addr != 0) begin
                m_regs[rd_addr] <= rd_data;
                nb[rd_addr] = 1'b0;
            end
            if (flush) nb = '0;
            else if (issue_en && issue_addr != 0) nb[issue_addr] = 1'b1;
            m_busy <= nb;
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REG_FILE_SB_BYPASS_EN
        if (reset && wr_en && rd_addr != 0 && rd_addr == a) return rd_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REG_FILE_SB_BYPASS_EN
        if (reset && wr_en && rd_addr != 0 && rd_addr == a)
            return issue_en && !flush && issue_addr == a;
`endif
        return m_busy[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cmp_rs1_data", 64'(rs1_data), 64'(exp_data(rs1_addr)));
            chk("cmp_rs2_data", 64'(rs2_data), 64'(exp_data(rs2_addr)));
            chk("cmp_rs1_busy", 64'(rs1_busy), 64'(exp_busy(rs1_addr)));
            chk("cmp_rs2_busy", 64'(rs2_busy), 64'(exp_busy(rs2_addr)));
            chk("cmp_busy_count", 64'(busy_count), 64'($countones(m_busy)));
        end
    end

    task automatic idle();
        wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        idle();
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; idle();
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_data = '0; issue_addr = '0;
        run_cmp = 1'b1;

        // Reset held: every address reads zero, writes and issues have no effect.
        wr_en = 1'b1; rd_addr = 5'd5; rd_data = 32'hCAFEF00D;
        issue_en = 1'b1; issue_addr = 5'd5;
        repeat (2) @(posedge clk);
        for (int a = 0; a < NREG; a++) begin
            rs1_addr = 5'(a); rs2_addr = 5'(NREG - 1 - a);
            #1;
            chk("rst_rs1_data", 64'(rs1_data), 64'h0);
            chk("rst_rs2_busy", 64'(rs2_busy), 64'h0);
        end
        chk("rst_busy_count", 64'(busy_count), 64'h0);
        idle();
        @(negedge clk); #1 reset = 1'b1;

        // Issue x5, then write it on the following cycle.
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        issue_en = 1'b1; issue_addr = 5'd5;
        tick();
        chk("x5_busy_after_issue", 64'(rs1_busy), 64'h1);
        chk("x5_rs2_busy_after_issue", 64'(rs2_busy), 64'h1);
        chk("x5_count_after_issue", 64'(busy_count), 64'h1);
        wr_en = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        tick();
        chk("x5_data", 64'(rs1_data), 64'hDEADBEEF);
        chk("x5_busy_after_write", 64'(rs1_busy), 64'h0);
        chk("x5_count_after_write", 64'(busy_count), 64'h0);

        // Same-cycle issue and write: issue wins.
        rs1_addr = 5'd7;
        issue_en = 1'b1; issue_addr = 5'd7;
        wr_en = 1'b1; rd_addr = 5'd7; rd_data = 32'h1234;
        tick();
        chk("x7_data", 64'(rs1_data), 64'h1234);
        chk("x7_busy", 64'(rs1_busy), 64'h1);
        chk("x7_count", 64'(busy_count), 64'h1);
        wr_en = 1'b1; rd_addr = 5'd7; rd_data = 32'h1234;
        tick();
        chk("x7_release_count", 64'(busy_count), 64'h0);

        // Three issues, then flush with a competing issue, then a write to x0.
        for (int r = 1; r <= 3; r++) begin
            issue_en = 1'b1; issue_addr = 5'(r);
            tick();
        end
        issue_en = 1'b1; issue_addr = 5'd2;
        tick();
        chk("issue_count_3", 64'(busy_count), 64'h3);
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd4; rs1_addr = 5'd4;
        tick();
        chk("flush_count", 64'(busy_count), 64'h0);
        chk("flush_x4_busy", 64'(rs1_busy), 64'h0);
        wr_en = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFF; rs1_addr = 5'd0;
        issue_en = 1'b1; issue_addr = 5'd0;
        tick();
        chk("x0_data", 64'(rs1_data), 64'h0);
        chk("x0_count", 64'(busy_count), 64'h0);

        // Read-during-write visibility.
        wr_en = 1'b1; rd_addr = 5'd9; rd_data = 32'h1111;
        tick();
        rs1_addr = 5'd9; rs2_addr = 5'd9;
        wr_en = 1'b1; rd_addr = 5'd9; rd_data = 32'hA5A5;
        #1;
`ifdef REG_FILE_SB_BYPASS_EN
        chk("x9_same_cycle", 64'(rs1_data), 64'hA5A5);
`else
        chk("x9_same_cycle", 64'(rs1_data), 64'h1111);
`endif
        tick();
        chk("x9_next_cycle", 64'(rs1_data), 64'hA5A5);
        chk("x9_rs2_next_cycle", 64'(rs2_data), 64'hA5A5);

        // Reset asserted mid-cycle discards the pending write and issue.
        issue_en = 1'b1; issue_addr = 5'd12;
        tick();
        wr_en = 1'b1; rd_addr = 5'd12; rd_data = 32'h77; issue_en = 1'b1; issue_addr = 5'd13;
        rs1_addr = 5'd12;
        @(negedge clk); #1 reset = 1'b0;
        #1;
        chk("midrst_count", 64'(busy_count), 64'h0);
        chk("midrst_x9", 64'(rs2_data), 64'h0);
        @(posedge clk); #1;
        chk("midrst_x12", 64'(rs1_data), 64'h0);
        idle();
        @(negedge clk); #1 reset = 1'b1;

        // First edge after reset release is fully functional.
        issue_en = 1'b1; issue_addr = 5'd13; rs1_addr = 5'd13;
        wr_en = 1'b1; rd_addr = 5'd14; rd_data = 32'h55; rs2_addr = 5'd14;
        tick();
        chk("post_rst_busy13", 64'(rs1_busy), 64'h1);
        chk("post_rst_data14", 64'(rs2_data), 64'h55);
        chk("post_rst_count", 64'(busy_count), 64'h1);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #2;
            wr_en      = ($urandom_range(0, 99) < 55);
            issue_en   = ($urandom_range(0, 99) < 50);
            flush      = ($urandom_range(0, 99) < 4);
            rd_addr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, NREG - 1));
            issue_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, NREG - 1));
            rd_data    = $urandom;
            rs1_addr   = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, NREG - 1));
            rs2_addr   = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, NREG - 1));
        end
        @(posedge clk); #2;
        idle();
        @(negedge clk); #1;
        run_cmp = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
